// File: rtl/bus_arb_pkg.sv
// Shared definitions for the system-bus host arbiter.
//   id_width()   : bits needed to name one host (never less than 1)
//   host_id_t    : container type for a host index
//   lock_state_e : state of the arbiter's request-lock FSM
//   rr_next()    : round-robin successor of a host index
package bus_arb_pkg;

  localparam int MaxIdWidth = 8;

  typedef logic [MaxIdWidth-1:0] host_id_t;

  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

  function automatic int id_width(input int nr_hosts);
    return (nr_hosts > 1) ? $clog2(nr_hosts) : 1;
  endfunction

  // Next host after cur, wrapping to 0 after the last one.
  function automatic host_id_t rr_next(input host_id_t cur, input int nr_hosts);
    host_id_t nxt;
    if (int'(cur) >= nr_hosts - 1) nxt = '0;
    else                           nxt = cur + host_id_t'(1);
    return nxt;
  endfunction

endpackage

// File: rtl/bus_host_arb_if.sv
// Signal bundle between the hosts, the arbiter and the downstream bus.
// Names keep the arbiter's point of view (_i = into the arbiter).
//
// Handshake (both host side and bus side): req/gnt. A requester raises req
// with addr/we/be/wdata and keeps them stable until gnt; the beat transfers
// in the cycle where req & gnt are both high. Every accepted beat is answered
// by exactly one rvalid pulse, in acceptance order, at least one cycle later.
//
// Modports:
//   master : the surroundings (hosts and bus fabric) driving requests/responses
//   slave  : the arbiter itself
interface bus_host_arb_if #(
  parameter int NrHosts   = 2,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
);
  logic [NrHosts-1:0]                  host_req_i;
  logic [NrHosts-1:0]                  host_we_i;
  logic [NrHosts-1:0][AddrWidth-1:0]   host_addr_i;
  logic [NrHosts-1:0][DataWidth/8-1:0] host_be_i;
  logic [NrHosts-1:0][DataWidth-1:0]   host_wdata_i;
  logic [NrHosts-1:0]                  host_gnt_o;
  logic [NrHosts-1:0]                  host_rvalid_o;
  logic [DataWidth-1:0]                host_rdata_o;

  logic                                bus_req_o;
  logic                                bus_we_o;
  logic [AddrWidth-1:0]                bus_addr_o;
  logic [DataWidth/8-1:0]              bus_be_o;
  logic [DataWidth-1:0]                bus_wdata_o;
  logic                                bus_gnt_i;
  logic                                bus_rvalid_i;
  logic [DataWidth-1:0]                bus_rdata_i;

  logic                                err_o;

  modport master (
    output host_req_i, host_we_i, host_addr_i, host_be_i, host_wdata_i,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i,
    input  host_gnt_o, host_rvalid_o, host_rdata_o,
    input  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    input  err_o
  );

  modport slave (
    input  host_req_i, host_we_i, host_addr_i, host_be_i, host_wdata_i,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i,
    output host_gnt_o, host_rvalid_o, host_rdata_o,
    output bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    output err_o
  );
endinterface

// File: rtl/bus_arb_id_fifo.sv
// In-order FIFO of host IDs, one entry per accepted-but-unanswered beat.
// Ports:
//   clk_i, rst_ni     : clock, asynchronous active-low reset (empties FIFO)
//   push, push_data   : enqueue an ID (ignored when full)
//   pop               : dequeue the head (ignored when empty)
//   head              : oldest stored ID
//   full, empty, count: occupancy, all derived from registers only
module bus_arb_id_fifo #(
  parameter  int Depth = 2,
  parameter  int Width = 1,
  localparam int CntW  = $clog2(Depth + 1),
  localparam int PtrW  = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (int'(p) == Depth - 1) ? '0 : p + PtrW'(1);
  endfunction

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_ok) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/bus_host_arb.sv
// Round-robin arbiter sharing one system-bus host port among NrHosts
// req/gnt/rvalid requesters. Requests pass through combinationally; an
// in-order ID FIFO routes each rvalid back to the host that issued the beat.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus           : host-side and bus-side signals (slave modport)
//   dbg_count_o   : outstanding-beat count
//   dbg_lock_o    : lock FSM state
//   dbg_rr_o      : round-robin start pointer
module bus_host_arb
  import bus_arb_pkg::*;
#(
  parameter  int NrHosts        = 2,
  parameter  int AddrWidth      = 32,
  parameter  int DataWidth      = 32,
  parameter  int MaxOutstanding = 2,
  localparam int IdW            = id_width(NrHosts),
  localparam int CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  bus_host_arb_if.slave    bus,
  output logic [CntW-1:0]  dbg_count_o,
  output lock_state_e      dbg_lock_o,
  output logic [IdW-1:0]   dbg_rr_o
);

  lock_state_e            lock_q;
  logic [IdW-1:0]         rr_q;
  logic [IdW-1:0]         sel_q;
  logic                   err_q;

  logic [IdW-1:0]         sel_free;
  logic [IdW-1:0]         hi_idx;
  logic [IdW-1:0]         lo_idx;
  logic                   found_hi;
  logic                   lock_active;
  logic [IdW-1:0]         sel;
  logic                   bus_req;
  logic                   gnt_fire;
  logic                   pop;

  logic [AddrWidth-1:0]   sel_addr;
  logic [DataWidth-1:0]   sel_wdata;
  logic [DataWidth/8-1:0] sel_be;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic [IdW-1:0]         fifo_head;
  logic [CntW-1:0]        fifo_count;

  // First requester at or above rr_q, else the lowest requester overall
  // (the wrap-around). Scanning downward leaves the lowest match last.
  always_comb begin
    found_hi = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NrHosts - 1; i >= 0; i--) begin
      if (bus.host_req_i[i]) begin
        lo_idx = IdW'(i);
        if (i >= int'(rr_q)) begin
          hi_idx   = IdW'(i);
          found_hi = 1'b1;
        end
      end
    end
    sel_free = found_hi ? hi_idx : lo_idx;
  end

  // A locked host that withdraws its request loses the lock at once, so a
  // fresh selection is made in the same cycle.
  assign lock_active = (lock_q == LOCK_HELD) && bus.host_req_i[sel_q];
  assign sel         = lock_active ? sel_q : sel_free;

  // Full uses the registered count only: no rvalid -> req path.
  assign bus_req  = (|bus.host_req_i) & ~fifo_full;
  assign gnt_fire = bus_req & bus.bus_gnt_i;
  assign pop      = bus.bus_rvalid_i & ~fifo_empty;

  assign sel_addr  = bus.host_addr_i[sel];
  assign sel_wdata = bus.host_wdata_i[sel];
  assign sel_be    = bus.host_be_i[sel];

  assign bus.bus_req_o    = bus_req;
  assign bus.bus_we_o     = bus.host_we_i[sel];
  assign bus.bus_addr_o   = sel_addr;
  assign bus.bus_wdata_o  = sel_wdata;
  assign bus.bus_be_o     = sel_be;
  assign bus.host_rdata_o = bus.bus_rdata_i;
  assign bus.err_o        = err_q;

  always_comb begin
    bus.host_gnt_o    = '0;
    bus.host_rvalid_o = '0;
    for (int i = 0; i < NrHosts; i++) begin
      bus.host_gnt_o[i]    = gnt_fire && (sel == IdW'(i));
      bus.host_rvalid_o[i] = pop && (fifo_head == IdW'(i));
    end
  end

  // Lock FSM plus round-robin pointer and sticky error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q <= LOCK_IDLE;
      sel_q  <= '0;
      rr_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      unique case (lock_q)
        LOCK_IDLE: begin
          if (bus_req && !bus.bus_gnt_i) begin
            lock_q <= LOCK_HELD;
            sel_q  <= sel;
          end
        end
        LOCK_HELD: begin
          if (gnt_fire) begin
            lock_q <= LOCK_IDLE;
          end else if (lock_active) begin
            // Kept even while the FIFO is full and bus_req is gated off.
            lock_q <= LOCK_HELD;
          end else if (bus_req && !bus.bus_gnt_i) begin
            sel_q  <= sel;
          end else begin
            lock_q <= LOCK_IDLE;
          end
        end
        default: lock_q <= LOCK_IDLE;
      endcase

      if (gnt_fire) rr_q <= IdW'(rr_next(host_id_t'(sel), NrHosts));
      if (bus.bus_rvalid_i && fifo_empty) err_q <= 1'b1;
    end
  end

  bus_arb_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdW)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (gnt_fire),
    .push_data (sel),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign dbg_count_o = fifo_count;
  assign dbg_lock_o  = lock_q;
  assign dbg_rr_o    = rr_q;

endmodule

// File: tb/tb_bus_host_arb.sv
module tb_bus_host_arb;
  import bus_arb_pkg::*;

  localparam int NrHosts        = 2;
  localparam int AddrWidth      = 32;
  localparam int DataWidth      = 32;
  localparam int MaxOutstanding = 2;
  localparam logic [31:0] ADDR0 = 32'h0000_1000;
  localparam logic [31:0] ADDR1 = 32'h0010_0000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  dbg_count;
  lock_state_e dbg_lock;
  logic [0:0]  dbg_rr;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_v;

  always #5 clk = ~clk;

  bus_host_arb_if #(
    .NrHosts(NrHosts), .AddrWidth(AddrWidth), .DataWidth(DataWidth)
  ) bif ();

  bus_host_arb #(
    .NrHosts(NrHosts), .AddrWidth(AddrWidth), .DataWidth(DataWidth),
    .MaxOutstanding(MaxOutstanding)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (bif.slave),
    .dbg_count_o (dbg_count),
    .dbg_lock_o  (dbg_lock),
    .dbg_rr_o    (dbg_rr)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    bif.host_req_i     = 2'b00;
    bif.host_we_i      = 2'b00;
    bif.host_addr_i[0] = ADDR0;
    bif.host_addr_i[1] = ADDR1;
    bif.host_be_i      = {4'hF, 4'hF};
    bif.host_wdata_i   = {32'h1111_1111, 32'h0000_0000};
    bif.bus_gnt_i      = 1'b0;
    bif.bus_rvalid_i   = 1'b0;
    bif.bus_rdata_i    = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    bif.host_req_i   = 2'b10;
    bif.bus_rvalid_i = 1'b1;
    settle();
    checks++; if (bif.bus_req_o !== 1'b1) begin errors++; $display("FAIL rst_bus_req: got %b want 1", bif.bus_req_o); end
    checks++; if (bif.bus_addr_o !== ADDR1) begin errors++; $display("FAIL rst_addr_h1: got %h want %h", bif.bus_addr_o, ADDR1); end
    checks++; if (bif.host_gnt_o !== 2'b00) begin errors++; $display("FAIL rst_gnt_none: got %b want 00", bif.host_gnt_o); end
    checks++; if (bif.host_rvalid_o !== 2'b00) begin errors++; $display("FAIL rst_rvalid: got %b want 00", bif.host_rvalid_o); end
    checks++; if (bif.err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", bif.err_o); end
    checks++; if (dbg_count !== 2'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", dbg_count); end
    bif.bus_gnt_i = 1'b1;
    settle();
    checks++; if (bif.host_gnt_o !== 2'b10) begin errors++; $display("FAIL rst_gnt_pass: got %b want 10", bif.host_gnt_o); end
    tick();
    bif.host_req_i = 2'b11;
    settle();
    checks++; if (bif.bus_addr_o !== ADDR0) begin errors++; $display("FAIL rst_addr_lowest: got %h want %h", bif.bus_addr_o, ADDR0); end
    idle_inputs();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single_host();
    idle_inputs();
    bif.host_req_i = 2'b10;
    settle();
    checks++; if (bif.bus_req_o !== 1'b1) begin errors++; $display("FAIL single_req: got %b want 1", bif.bus_req_o); end
    checks++; if (bif.bus_addr_o !== ADDR1) begin errors++; $display("FAIL single_addr: got %h want %h", bif.bus_addr_o, ADDR1); end
    checks++; if (bif.host_gnt_o !== 2'b00) begin errors++; $display("FAIL single_nogntyet: got %b want 00", bif.host_gnt_o); end
    tick();
    bif.bus_gnt_i = 1'b1;
    settle();
    checks++; if (dbg_lock !== LOCK_HELD) begin errors++; $display("FAIL single_lock: got %0d want %0d", dbg_lock, LOCK_HELD); end
    checks++; if (bif.host_gnt_o !== 2'b10) begin errors++; $display("FAIL single_gnt: got %b want 10", bif.host_gnt_o); end
    tick();
    idle_inputs();
    settle();
    checks++; if (dbg_count !== 2'd1) begin errors++; $display("FAIL single_count: got %0d want 1", dbg_count); end
    checks++; if (dbg_rr !== 1'b0) begin errors++; $display("FAIL single_rr: got %0d want 0", dbg_rr); end
    checks++; if (dbg_lock !== LOCK_IDLE) begin errors++; $display("FAIL single_unlock: got %0d want %0d", dbg_lock, LOCK_IDLE); end
    tick();
    bif.bus_rvalid_i = 1'b1;
    bif.bus_rdata_i  = 32'hDEAD_BEEF;
    settle();
    checks++; if (bif.host_rvalid_o !== 2'b10) begin errors++; $display("FAIL single_rvalid: got %b want 10", bif.host_rvalid_o); end
    checks++; if (bif.host_rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rdata: got %h want deadbeef", bif.host_rdata_o); end
    tick();
    idle_inputs();
    settle();
    checks++; if (dbg_count !== 2'd0) begin errors++; $display("FAIL single_drain: got %0d want 0", dbg_count); end
    tick();
  endtask

  // Both hosts request every cycle, gnt always high, each beat answered the
  // following cycle: grants alternate 0,1,0,1 and responses follow them.
  task automatic test_contention();
    logic [1:0]  exp_g;
    logic [31:0] exp_a;
    idle_inputs();
    bif.host_req_i = 2'b11;
    bif.bus_gnt_i  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bif.bus_rvalid_i = (k > 0);
      bif.bus_rdata_i  = 32'(k);
      settle();
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_a = (k % 2 == 0) ? ADDR0 : ADDR1;
      checks++; if (bif.host_gnt_o !== exp_g) begin errors++; $display("FAIL cont_gnt[%0d]: got %b want %b", k, bif.host_gnt_o, exp_g); end
      checks++; if (bif.bus_addr_o !== exp_a) begin errors++; $display("FAIL cont_addr[%0d]: got %h want %h", k, bif.bus_addr_o, exp_a); end
      if (k > 0) begin
        exp_v = exp_q.pop_front();
        checks++; if (bif.host_rvalid_o !== exp_v) begin errors++; $display("FAIL cont_rvalid[%0d]: got %b want %b", k, bif.host_rvalid_o, exp_v); end
        checks++; if (dbg_count !== 2'd1) begin errors++; $display("FAIL cont_count[%0d]: got %0d want 1", k, dbg_count); end
      end
      exp_q.push_back(exp_g);
      tick();
    end
    bif.host_req_i   = 2'b00;
    bif.bus_gnt_i    = 1'b0;
    bif.bus_rvalid_i = 1'b1;
    settle();
    exp_v = exp_q.pop_front();
    checks++; if (bif.host_rvalid_o !== exp_v) begin errors++; $display("FAIL cont_last_rvalid: got %b want %b", bif.host_rvalid_o, exp_v); end
    tick();
    idle_inputs();
  endtask

  // Host 1 locks the bus; host 0 arriving later must not steal it.
  task automatic test_lock();
    idle_inputs();
    bif.host_req_i = 2'b10;
    settle();
    checks++; if (bif.bus_addr_o !== ADDR1) begin errors++; $display("FAIL lock_first_addr: got %h want %h", bif.bus_addr_o, ADDR1); end
    tick();
    bif.host_req_i = 2'b11;
    for (int j = 0; j < 3; j++) begin
      settle();
      checks++; if (bif.bus_addr_o !== ADDR1) begin errors++; $display("FAIL lock_hold_addr[%0d]: got %h want %h", j, bif.bus_addr_o, ADDR1); end
      checks++; if (bif.host_gnt_o !== 2'b00) begin errors++; $display("FAIL lock_hold_gnt[%0d]: got %b want 00", j, bif.host_gnt_o); end
      tick();
    end
    bif.bus_gnt_i = 1'b1;
    settle();
    checks++; if (bif.host_gnt_o !== 2'b10) begin errors++; $display("FAIL lock_gnt_h1: got %b want 10", bif.host_gnt_o); end
    exp_q.push_back(2'b10);
    tick();
    bif.host_req_i = 2'b01;
    settle();
    checks++; if (bif.host_gnt_o !== 2'b01) begin errors++; $display("FAIL lock_gnt_h0: got %b want 01", bif.host_gnt_o); end
    checks++; if (bif.bus_addr_o !== ADDR0) begin errors++; $display("FAIL lock_addr_h0: got %h want %h", bif.bus_addr_o, ADDR0); end
    exp_q.push_back(2'b01);
    tick();
    idle_inputs();
    for (int j = 0; j < 2; j++) begin
      bif.bus_rvalid_i = 1'b1;
      settle();
      exp_v = exp_q.pop_front();
      checks++; if (bif.host_rvalid_o !== exp_v) begin errors++; $display("FAIL lock_rvalid[%0d]: got %b want %b", j, bif.host_rvalid_o, exp_v); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_full();
    idle_inputs();
    bif.bus_gnt_i  = 1'b1;
    bif.host_req_i = 2'b10;
    settle();
    checks++; if (bif.host_gnt_o !== 2'b10) begin errors++; $display("FAIL full_gnt1: got %b want 10", bif.host_gnt_o); end
    exp_q.push_back(2'b10);
    tick();
    bif.host_req_i = 2'b01;
    settle();
    checks++; if (bif.host_gnt_o !== 2'b01) begin errors++; $display("FAIL full_gnt2: got %b want 01", bif.host_gnt_o); end
    exp_q.push_back(2'b01);
    tick();
    settle();
    checks++; if (dbg_count !== 2'd2) begin errors++; $display("FAIL full_count: got %0d want 2", dbg_count); end
    checks++; if (bif.bus_req_o !== 1'b0) begin errors++; $display("FAIL full_req_gated: got %b want 0", bif.bus_req_o); end
    checks++; if (bif.host_gnt_o !== 2'b00) begin errors++; $display("FAIL full_no_gnt: got %b want 00", bif.host_gnt_o); end
    tick();
    bif.bus_rvalid_i = 1'b1;
    settle();
    checks++; if (bif.bus_req_o !== 1'b0) begin errors++; $display("FAIL full_no_lookahead: got %b want 0", bif.bus_req_o); end
    exp_v = exp_q.pop_front();
    checks++; if (bif.host_rvalid_o !== exp_v) begin errors++; $display("FAIL full_rvalid_oldest: got %b want %b", bif.host_rvalid_o, exp_v); end
    tick();
    bif.bus_rvalid_i = 1'b0;
    settle();
    checks++; if (bif.bus_req_o !== 1'b1) begin errors++; $display("FAIL full_req_back: got %b want 1", bif.bus_req_o); end
    checks++; if (bif.host_gnt_o !== 2'b01) begin errors++; $display("FAIL full_gnt3: got %b want 01", bif.host_gnt_o); end
    exp_q.push_back(2'b01);
    tick();
    idle_inputs();
    for (int j = 0; j < 2; j++) begin
      bif.bus_rvalid_i = 1'b1;
      settle();
      exp_v = exp_q.pop_front();
      checks++; if (bif.host_rvalid_o !== exp_v) begin errors++; $display("FAIL full_drain[%0d]: got %b want %b", j, bif.host_rvalid_o, exp_v); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_push_pop();
    idle_inputs();
    bif.bus_gnt_i  = 1'b1;
    bif.host_req_i = 2'b01;
    settle();
    checks++; if (bif.host_gnt_o !== 2'b01) begin errors++; $display("FAIL pp_gnt0: got %b want 01", bif.host_gnt_o); end
    exp_q.push_back(2'b01);
    tick();
    bif.host_req_i   = 2'b10;
    bif.bus_rvalid_i = 1'b1;
    settle();
    checks++; if (bif.host_gnt_o !== 2'b10) begin errors++; $display("FAIL pp_gnt1: got %b want 10", bif.host_gnt_o); end
    exp_v = exp_q.pop_front();
    checks++; if (bif.host_rvalid_o !== exp_v) begin errors++; $display("FAIL pp_pop_older: got %b want %b", bif.host_rvalid_o, exp_v); end
    exp_q.push_back(2'b10);
    tick();
    idle_inputs();
    settle();
    checks++; if (dbg_count !== 2'd1) begin errors++; $display("FAIL pp_count: got %0d want 1", dbg_count); end
    tick();
    bif.bus_rvalid_i = 1'b1;
    settle();
    exp_v = exp_q.pop_front();
    checks++; if (bif.host_rvalid_o !== exp_v) begin errors++; $display("FAIL pp_drain: got %b want %b", bif.host_rvalid_o, exp_v); end
    tick();
    idle_inputs();
    settle();
    checks++; if (dbg_count !== 2'd0) begin errors++; $display("FAIL pp_empty: got %0d want 0", dbg_count); end
    tick();
  endtask

  task automatic test_spurious();
    idle_inputs();
    bif.bus_rvalid_i = 1'b1;
    bif.bus_rdata_i  = 32'h0BAD_0BAD;
    settle();
    checks++; if (bif.host_rvalid_o !== 2'b00) begin errors++; $display("FAIL spur_rvalid: got %b want 00", bif.host_rvalid_o); end
    checks++; if (bif.err_o !== 1'b0) begin errors++; $display("FAIL spur_err_before: got %b want 0", bif.err_o); end
    tick();
    idle_inputs();
    settle();
    checks++; if (bif.err_o !== 1'b1) begin errors++; $display("FAIL spur_err_set: got %b want 1", bif.err_o); end
    tick();
    tick();
    settle();
    checks++; if (bif.err_o !== 1'b1) begin errors++; $display("FAIL spur_err_sticky: got %b want 1", bif.err_o); end
    tick();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    bif.bus_gnt_i  = 1'b1;
    bif.host_req_i = 2'b01;
    settle();
    checks++; if (bif.host_gnt_o !== 2'b01) begin errors++; $display("FAIL mid_pre_gnt: got %b want 01", bif.host_gnt_o); end
    tick();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    checks++; if (bif.err_o !== 1'b0) begin errors++; $display("FAIL mid_err_clr: got %b want 0", bif.err_o); end
    checks++; if (dbg_count !== 2'd0) begin errors++; $display("FAIL mid_count_clr: got %0d want 0", dbg_count); end
    checks++; if (dbg_rr !== 1'b0) begin errors++; $display("FAIL mid_rr_clr: got %0d want 0", dbg_rr); end
    tick();
    rst_n = 1'b1;
    bif.bus_rvalid_i = 1'b1;
    settle();
    checks++; if (bif.host_rvalid_o !== 2'b00) begin errors++; $display("FAIL mid_stale_rvalid: got %b want 00", bif.host_rvalid_o); end
    tick();
    idle_inputs();
    settle();
    checks++; if (bif.err_o !== 1'b1) begin errors++; $display("FAIL mid_stale_err: got %b want 1", bif.err_o); end
    tick();
    bif.host_req_i = 2'b11;
    bif.bus_gnt_i  = 1'b1;
    settle();
    checks++; if (bif.host_gnt_o !== 2'b01) begin errors++; $display("FAIL mid_first_gnt: got %b want 01", bif.host_gnt_o); end
    tick();
    idle_inputs();
    bif.bus_rvalid_i = 1'b1;
    settle();
    checks++; if (bif.host_rvalid_o !== 2'b01) begin errors++; $display("FAIL mid_rvalid: got %b want 01", bif.host_rvalid_o); end
    tick();
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    test_reset();
    test_single_host();
    test_contention();
    test_lock();
    test_full();
    test_push_pop();
    test_spurious();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
